coord_to_bank: RTL
==================

COORD_TO_BANK -- requirements
Module: coord_to_bank

Interface
REQ-001 The block SHALL expose parameters: QW, default $clog2(`max_num_Wt*`max_num_Ht)+2-1, quotient width; RW, default $clog2(`max_num_Wt)+1, remainder/divisor width; KW, default $clog2(`max_num_K)+1, filter-index width; DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 Port: clk  in  1  the single clock.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: res_rdy  in  1  upstream divider result valid.
REQ-005 Port: quotient  in  QW  tile row index.
REQ-006 Port: remainder  in  RW  tile column index.
REQ-007 Port: k_in  in  KW  filter index riding with the result.
REQ-008 Port: num_Wt  in  RW  tiles per row (divisor in use), static while busy.
REQ-009 Port: num_Ht  in  QW  tile rows, static while busy.
REQ-010 Port: flush  in  1  one-cycle pulse; discard all buffered entries.
REQ-011 Port: stall  out  1  freezes the upstream divider pipeline.
REQ-012 Port: out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-013 Port: out_bank  out  2  accumulator bank {row[0],col[0]}.
REQ-014 Port: out_offset  out  QW+RW  word offset within bank.
REQ-015 Port: out_k  out  KW  filter index.
REQ-016 Port: drop_cnt  out  16  dropped out-of-range results (saturating).

Function
REQ-017 A result SHALL be accepted on a cycle with res_rdy=1 and stall=0; nothing SHALL be accepted while stall=1 (upstream holds its output stable).
REQ-018 stall SHALL be asserted combinationally when occupancy==DEPTH or state==FLUSH, else 0.
REQ-019 Per accepted result: bank={quotient[0],remainder[0]}; offset=(quotient>>1)*((num_Wt+1)>>1)+(remainder>>1), computed at full QW+RW width, no truncation.
REQ-020 Mapping SHALL be registered once (one pipeline stage) and written into the FIFO; accepted result appears on out_* no earlier than 2 cycles after acceptance when FIFO empty and out_ready=1.
REQ-021 out_valid=1 when FIFO non-empty; entry pops on out_valid&&out_ready; out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop at occupancy==DEPTH: stall stays asserted that cycle (no bypass); occupancy unchanged by simultaneous push/pop otherwise.
REQ-023 The mapping stage register SHALL count toward occupancy so stall accounts for the in-flight entry; no entry SHALL ever be lost or duplicated.
REQ-024 FSM states: RUN, FLUSH. RUN->FLUSH on flush=1; in FLUSH the FIFO and mapping stage are cleared in one cycle; FLUSH->RUN the next cycle. flush while in FLUSH is ignored.
REQ-025 Pointers SHALL wrap modulo DEPTH; an extra occupancy bit distinguishes full from empty.

Reset
REQ-026 On rst=1 at a clk edge: state=RUN, FIFO empty, mapping stage invalid, out_valid=0, out_bank=0, out_offset=0, out_k=0, drop_cnt=0, stall=0.
REQ-027 Reset SHALL take priority over flush and any handshake in the same cycle; reset mid-transfer discards all entries.

Configuration
REQ-028 With COORD_RANGE_CHECK_EN defined: a result with quotient>=num_Ht or remainder>=num_Wt SHALL be accepted but not enqueued, and drop_cnt increments (saturates at 16'hFFFF).
REQ-029 Without COORD_RANGE_CHECK_EN: every accepted result is enqueued and drop_cnt SHALL be tied to 0.

Structure
REQ-030 A shared package SHALL hold: the FSM state enum, the FIFO entry struct {bank, offset, k}, and derived width constants.
REQ-031 The FIFO SHALL be a sub-module named coord_fifo (parameterised DEPTH, entry type); mapping and FSM live in coord_to_bank.

Verification
REQ-032 num_Wt=5, q=3,r=4,k=7, out_ready=1 -> out_bank=2'b10, out_offset=1*3+2=5, out_k=7, 2 cycles after accept.
REQ-033 out_ready=0, continuous res_rdy -> exactly DEPTH entries accepted, stall=1 thereafter; release -> entries emerge in order, none lost.
REQ-034 flush with 3 entries queued -> stall=1 one cycle, out_valid=0 next cycle, following result passes normally.
REQ-035 COORD_RANGE_CHECK_EN, num_Ht=4, q=4 -> no output, drop_cnt=1; without macro -> output produced, drop_cnt=0.
REQ-036 rst asserted while full and out_ready=0 -> next cycle all outputs per REQ-026.
REQ-037 Random res_rdy/out_ready for 10k results vs scoreboard -> order and values match, stall never asserted with occupancy<DEPTH in RUN.

Source files
------------

// File: rtl/coord_to_bank_pkg.sv
// Shared types and width constants for coord_to_bank and its FIFO.
// Default tile limits apply when max_num_Wt / max_num_Ht / max_num_K are not predefined.
`ifndef max_num_Wt
`define max_num_Wt 16
`endif
`ifndef max_num_Ht
`define max_num_Ht 16
`endif
`ifndef max_num_K
`define max_num_K 16
`endif

package coord_to_bank_pkg;

    localparam int CTB_QW = $clog2(`max_num_Wt * `max_num_Ht) + 2 - 1;
    localparam int CTB_RW = $clog2(`max_num_Wt) + 1;
    localparam int CTB_KW = $clog2(`max_num_K) + 1;
    localparam int CTB_OW = CTB_QW + CTB_RW;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctb_state_e;

    typedef struct packed {
        logic [1:0]        bank;
        logic [CTB_OW-1:0] offset;
        logic [CTB_KW-1:0] k;
    } coord_entry_t;

    // Bank select interleaves even/odd rows and columns across four accumulators.
    function automatic logic [1:0] bank_of(input logic row_lsb, input logic col_lsb);
        return {row_lsb, col_lsb};
    endfunction

endpackage

// File: rtl/coord_fifo.sv
// Power-of-two FIFO with first-word-fall-through output for coord_to_bank entries.
// Output data reads as zero whenever the FIFO is empty.
module coord_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    T              mem_q [DEPTH];

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally at DEPTH; count carries the extra bit for full vs empty.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = !empty;
    assign data_o  = empty ? T'('0) : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/coord_to_bank.sv
// Maps divider (row, column) results to accumulator bank + word offset and buffers them.
// Optional COORD_RANGE_CHECK_EN drops results outside num_Ht x num_Wt and counts them.
`ifndef max_num_Wt
`define max_num_Wt 16
`endif
`ifndef max_num_Ht
`define max_num_Ht 16
`endif
`ifndef max_num_K
`define max_num_K 16
`endif

module coord_to_bank
    import coord_to_bank_pkg::*;
#(
    parameter int QW    = $clog2(`max_num_Wt * `max_num_Ht) + 2 - 1,
    parameter int RW    = $clog2(`max_num_Wt) + 1,
    parameter int KW    = $clog2(`max_num_K) + 1,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               res_rdy,
    input  logic [QW-1:0]      quotient,
    input  logic [RW-1:0]      remainder,
    input  logic [KW-1:0]      k_in,
    input  logic [RW-1:0]      num_Wt,
    input  logic [QW-1:0]      num_Ht,
    input  logic               flush,
    output logic               stall,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_bank,
    output logic [QW+RW-1:0]   out_offset,
    output logic [KW-1:0]      out_k,
    output logic [15:0]        drop_cnt
);

    localparam int OW = QW + RW;
    localparam int CW = $clog2(DEPTH) + 1;

    ctb_state_e   state_q;
    logic         map_vld_q;
    logic         map_vld_d;
    coord_entry_t map_q;
    coord_entry_t map_d;

    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] occ;
    coord_entry_t  head;
    logic          accept;
    logic          in_range;

    logic [OW-1:0] q_half;
    logic [OW-1:0] w_half;
    logic [OW-1:0] r_half;
    logic [OW-1:0] offset_calc;

    // The mapping register counts as occupied, so stall reflects the in-flight entry too.
    assign occ    = fifo_cnt + CW'(map_vld_q);
    assign stall  = (occ == CW'(DEPTH)) || (state_q == ST_FLUSH);
    assign accept = res_rdy && !stall;

`ifdef COORD_RANGE_CHECK_EN
    logic [15:0] drop_q;
    logic [15:0] drop_d;

    assign in_range = (quotient < num_Ht) && (remainder < num_Wt);

    always_comb begin
        drop_d = drop_q;
        if (accept && !in_range && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    logic unused_num_ht;

    assign in_range      = 1'b1;
    assign unused_num_ht = ^num_Ht;
    assign drop_cnt      = '0;
`endif

    // Offset is row-pair index times column-pairs per row plus column-pair index.
    always_comb begin
        q_half      = OW'(quotient >> 1);
        w_half      = OW'({1'b0, num_Wt} + (RW+1)'(1)) >> 1;
        r_half      = OW'(remainder >> 1);
        offset_calc = q_half * w_half + r_half;
    end

    always_comb begin
        map_vld_d    = accept && in_range;
        map_d.bank   = bank_of(quotient[0], remainder[0]);
        map_d.offset = offset_calc;
        map_d.k      = k_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   state_q <= flush ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state_q == ST_FLUSH)) begin
            map_vld_q <= 1'b0;
            map_q     <= '0;
        end else begin
            map_vld_q <= map_vld_d;
            if (map_vld_d) begin
                map_q <= map_d;
            end
        end
    end

    // Room is guaranteed for the staged entry because occupancy never exceeds DEPTH.
    coord_fifo #(
        .DEPTH (DEPTH),
        .T     (coord_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q == ST_FLUSH),
        .push_i  (map_vld_q),
        .data_i  (map_q),
        .pop_i   (out_valid && out_ready),
        .data_o  (head),
        .valid_o (out_valid),
        .count_o (fifo_cnt)
    );

    assign out_bank   = head.bank;
    assign out_offset = head.offset;
    assign out_k      = head.k;

endmodule
